// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, the padder/emitter state encoding and a small length helper.
// Other SHA-256 datapath blocks import this package as well.
package sha256_pkg;

  localparam int SHA256_ROUNDS      = 64;
  localparam int SHA256_BLOCK_WORDS = 16;
  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_CORE,
    EMIT,
    GAP
  } state_t;

  // Message bits carried by one input word; a final word with n==0 is a full word.
  function automatic logic [5:0] word_bits(input logic is_last, input logic [1:0] n);
    if (is_last && (n != 2'd0)) return {1'b0, n, 3'b000};
    return 6'd32;
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Message stream in, schedule word stream out, plus block framing flags.
// master = message source / hash core side, slave = padder.
interface sha256_msg_padder_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_bytes;
  logic        hash_ready;
  logic [31:0] data;
  logic        write_enable;
  logic        inner_busy;
  logic        first_block;
  logic        last_block;
  logic        busy;

  modport master (
    output in_valid, in_data, in_last, in_bytes, hash_ready,
    input  in_ready, data, write_enable, inner_busy, first_block, last_block, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, hash_ready,
    output in_ready, data, write_enable, inner_busy, first_block, last_block, busy
  );

endinterface

// File: rtl/sha256_pad_word.sv
// Masks the final message word: keeps the first n bytes, drops in the 0x80 marker
// right after them and zeroes the rest. Full or non-final words pass through.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  n,
  input  logic        is_last,
  output logic [31:0] padded
);

  logic [2:0] keep;
  assign keep = (n == 2'd0) ? 3'd4 : {1'b0, n};

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    localparam logic [2:0] POS = 3'(gi);
    assign padded[31-8*gi -: 8] = (!is_last || (POS < keep)) ? word[31-8*gi -: 8] :
                                  (POS == keep)              ? SHA256_PAD_BYTE :
                                                               8'h00;
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: fills a 16-word block buffer from the message stream, appends
// 0x80 / zeros / bit length, and replays each block to the schedule in a 64-cycle window.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W      = 64,
  parameter int GAP_CYCLES = 1
) (
  input logic               clk,
  input logic               reset,
  sha256_msg_padder_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state_reg;
  logic [5:0]       k_reg;
  logic [4:0]       f_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [LEN_W-1:0] len_reg;
  logic             msg_ended_reg;
  logic             tail_reg;
  logic             need80_reg;
  logic             len_placed_reg;
  logic             blk_final_reg;
  logic             first_pending_reg;
  logic             msg_done_reg;
  logic             inner_busy_reg;
  logic             write_enable_reg;
  logic             first_block_reg;
  logic             last_block_reg;
  logic             busy_reg;

  logic [31:0] mem [SHA256_BLOCK_WORDS];
  logic [31:0] rd_word_reg;

  logic        fill_active;
  logic        can_write;
  logic        in_ready;
  logic        take;
  logic        gen;
  logic        wr_en;
  logic [31:0] pad_out;
  logic [31:0] gen_word;
  logic [31:0] wr_data;
  logic [63:0] len_ext;
  logic [3:0]  rd_addr;

  sha256_pad_word u_pad_word (
    .word    (bus.in_data),
    .n       (bus.in_bytes),
    .is_last (bus.in_last),
    .padded  (pad_out)
  );

  assign len_ext = 64'(len_reg);

  // The buffer is writable outside the replay of words 0..15.
  assign fill_active = (state_reg == FILL) || (state_reg == GAP) ||
                       ((state_reg == EMIT) && (k_reg >= 6'(SHA256_BLOCK_WORDS)));
  assign can_write   = fill_active && !f_reg[4];
  assign in_ready    = can_write && !msg_ended_reg;
  assign take        = in_ready && bus.in_valid;
  assign gen         = can_write && tail_reg;
  assign wr_en       = take || gen;
  assign wr_data     = tail_reg ? gen_word : pad_out;
  assign rd_addr     = (state_reg == EMIT) ? (k_reg[3:0] + 4'd1) : 4'd0;

  // Padding words produced without input once the final message word is in.
  always_comb begin
    gen_word = 32'd0;
    if (need80_reg)
      gen_word = {SHA256_PAD_BYTE, 24'd0};
    else if (f_reg == 5'd14)
      gen_word = len_ext[63:32];
    else if ((f_reg == 5'd15) && len_placed_reg)
      gen_word = len_ext[31:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[f_reg[3:0]] <= wr_data;
    rd_word_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      k_reg             <= '0;
      f_reg             <= '0;
      gap_reg           <= '0;
      len_reg           <= '0;
      msg_ended_reg     <= 1'b0;
      tail_reg          <= 1'b0;
      need80_reg        <= 1'b0;
      len_placed_reg    <= 1'b0;
      blk_final_reg     <= 1'b0;
      first_pending_reg <= 1'b1;
      msg_done_reg      <= 1'b0;
      inner_busy_reg    <= 1'b0;
      write_enable_reg  <= 1'b0;
      first_block_reg   <= 1'b0;
      last_block_reg    <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      if (take) begin
        f_reg   <= f_reg + 5'd1;
        len_reg <= len_reg + LEN_W'(word_bits(bus.in_last, bus.in_bytes));
        if (bus.in_last) begin
          msg_ended_reg <= 1'b1;
          tail_reg      <= 1'b1;
          need80_reg    <= (bus.in_bytes == 2'd0);
        end
      end else if (gen) begin
        f_reg <= f_reg + 5'd1;
        if (need80_reg)
          need80_reg <= 1'b0;
        else if (f_reg == 5'd14)
          len_placed_reg <= 1'b1;
        else if ((f_reg == 5'd15) && len_placed_reg) begin
          tail_reg       <= 1'b0;
          len_placed_reg <= 1'b0;
          blk_final_reg  <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          state_reg <= FILL;
          busy_reg  <= 1'b1;
        end
        FILL: begin
          if (f_reg[4]) state_reg <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (bus.hash_ready) begin
            state_reg         <= EMIT;
            k_reg             <= '0;
            inner_busy_reg    <= 1'b1;
            write_enable_reg  <= 1'b1;
            first_block_reg   <= first_pending_reg;
            last_block_reg    <= blk_final_reg;
            first_pending_reg <= blk_final_reg;
            f_reg             <= '0;
            blk_final_reg     <= 1'b0;
            // Length is already in the buffer, so the next message can start counting now.
            if (blk_final_reg) begin
              msg_ended_reg <= 1'b0;
              len_reg       <= '0;
            end
          end
        end
        EMIT: begin
          k_reg            <= k_reg + 6'd1;
          write_enable_reg <= (k_reg < 6'(SHA256_BLOCK_WORDS - 1));
          if (k_reg == 6'(SHA256_ROUNDS - 1)) begin
            state_reg       <= GAP;
            inner_busy_reg  <= 1'b0;
            first_block_reg <= 1'b0;
            last_block_reg  <= 1'b0;
            msg_done_reg    <= last_block_reg;
            gap_reg         <= '0;
          end
        end
        GAP: begin
          if (gap_reg == GAP_W'(GAP_CYCLES - 1)) begin
            if (msg_done_reg) begin
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              msg_done_reg <= 1'b0;
            end else if (f_reg[4]) begin
              state_reg <= WAIT_CORE;
            end else begin
              state_reg <= FILL;
            end
          end else begin
            gap_reg <= gap_reg + GAP_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.data         = write_enable_reg ? rd_word_reg : 32'd0;
  assign bus.write_enable = write_enable_reg;
  assign bus.inner_busy   = inner_busy_reg;
  assign bus.first_block  = first_block_reg;
  assign bus.last_block   = last_block_reg;
  assign bus.busy         = busy_reg;

endmodule
